bradford_gain_calculator: RTL and testbench
===========================================

// Module: bradford_gain_calculator
// PURPOSE
//  Downstream of the CCT->XYZ converter. Takes the source white XYZ (Q16.16, one valid pulse).
//  Maps it to Bradford LMS cone space and divides the fixed destination-white (D65) LMS by the
//  source LMS. Emits three per-channel von Kries gains (Q16.16) to the adaptation matrix stage.
//  Uses one shared multiplier and one iterative divider; not pipelined.
// PARAMETERS
//  DST_L      61698  D65 LMS L component, Q16.16 (0.94143)
//  DST_M      68185  D65 LMS M component, Q16.16 (1.04042)
//  DST_S      71404  D65 LMS S component, Q16.16 (1.08953)
//  DIV_ITERS  48     restoring-divider iterations per channel (48-bit dividend DST<<16)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous, active-high reset
//  xyz_in     in   3x32     source white X,Y,Z; unsigned Q16.16; index 0=X,1=Y,2=Z
//  xyz_valid  in   1        one-cycle strobe; xyz_in sampled on the same edge
//  gain_out   out  3x32     L,M,S gains; Q16.16; index 0=L,1=M,2=S
//  gain_valid out  1        one-cycle pulse; gain_out stable until next pulse or reset
//  gain_err   out  1        registered with gain_valid: some channel had LMS_src<=0 or overflow
//  busy       out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: gain_out=0, gain_valid=0, gain_err=0, busy=0, state=IDLE; all internal regs cleared.
//  FSM IDLE -> MAC -> DIV -> DONE -> IDLE.
//   IDLE: xyz_valid=1 captures xyz_in at edge N and enters MAC. Inputs are not re-sampled later.
//   MAC: 9 cycles, one product per cycle, row-major.
//    Each product is signed 33x32 -> 64-bit: xyz zero-extended, Bradford coefficient signed.
//    Accumulate each row in 64 bits. At row end: arithmetic >>16 (floor), saturate to signed 32 -> lms[i].
//   DIV: channels L,M,S in order, DIV_ITERS cycles each.
//    Quotient = (DST_x<<16)/lms[i], unsigned restoring division via sub-module.
//    If lms[i]<=0, skip the divide (still spend DIV_ITERS cycles), gain=0x7FFF_FFFF, set err.
//    If quotient > 0x7FFF_FFFF: saturate to 0x7FFF_FFFF and set err.
//   DONE: 1 cycle; registers gains/err to outputs, pulses gain_valid, returns to IDLE.
//  Latency: LATENCY = 1 + 9 + 3*DIV_ITERS = 154.
//   gain_valid is high in the cycle after edge N+153, i.e. 154 clocks after the accepting edge.
//  Handshake:
//   - xyz_valid while busy=1 (including the DONE cycle) is ignored, not queued.
//   - A strobe in the cycle after gain_valid is accepted. Min request spacing = 155 cycles.
//  gain_out/gain_err change only in DONE. A held-high xyz_valid starts a new job each time IDLE is reached.
//  rst mid-operation: abort at next edge, outputs to reset values, no gain_valid for the aborted job.
//  Bradford coefficients, Q16.16 signed:
//   [58661 17459 -10578; -49165 112296 2405; 2549 -4489 67476]
// STRUCTURE
//  Shared package ca_fixed_pkg holds:
//   - Q16.16 width/frac constants
//   - the 9 Bradford coefficients (also used by the later adaptation matrix stage)
//   - default D65 LMS constants
//   - the FSM state encoding
//  Sub-module seq_divider (start/done, WIDTH=48, unsigned restoring, one bit per cycle) with its own unit bench.
//  Top holds the FSM, the MAC row/column counters, the accumulator and the saturation logic.
// TESTING  (tolerance +/-16 LSB unless stated)
//  1. D65 xyz=(62291,65536,71358) -> gain_valid at +154 clk; gains=(65536,65536,65536)+/-16; err=0.
//  2. Illum A xyz=(71991,65536,23321) -> gains ~ (51749,75554,209634); err=0.
//  3. xyz=(0,0,0) -> all gains 0x7FFF_FFFF, gain_err=1, latency still 154.
//  4. Strobe, second strobe 5 clk later -> exactly one gain_valid, values from first xyz.
//     busy=1 for 154 clk after the first strobe.
//  5. Strobe, rst at +50 clk -> no gain_valid; outputs 0, busy=0. Fresh strobe -> correct result at +154.
//  6. Strobe on the cycle gain_valid=1 -> ignored.
//     Strobe on the next cycle -> accepted; second gain_valid exactly 155 clk after the first.

Source files
------------

// File: rtl/ca_fixed_pkg.sv
// Shared Q16.16 fixed-point constants for the chromatic adaptation chain:
// Bradford cone matrix, default D65 LMS white, and the gain-stage FSM encoding.
package ca_fixed_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam logic [31:0] D65_L    = 32'd61698;
  localparam logic [31:0] D65_M    = 32'd68185;
  localparam logic [31:0] D65_S    = 32'd71404;
  localparam logic [31:0] GAIN_MAX = 32'h7FFF_FFFF;

  localparam logic signed [31:0] BRAD_00 = 32'sd58661;
  localparam logic signed [31:0] BRAD_01 = 32'sd17459;
  localparam logic signed [31:0] BRAD_02 = -32'sd10578;
  localparam logic signed [31:0] BRAD_10 = -32'sd49165;
  localparam logic signed [31:0] BRAD_11 = 32'sd112296;
  localparam logic signed [31:0] BRAD_12 = 32'sd2405;
  localparam logic signed [31:0] BRAD_20 = 32'sd2549;
  localparam logic signed [31:0] BRAD_21 = -32'sd4489;
  localparam logic signed [31:0] BRAD_22 = 32'sd67476;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic signed [31:0] bradford_coef(input logic [1:0] row,
                                                       input logic [1:0] col);
    case ({row, col})
      4'h0:    return BRAD_00;
      4'h1:    return BRAD_01;
      4'h2:    return BRAD_02;
      4'h4:    return BRAD_10;
      4'h5:    return BRAD_11;
      4'h6:    return BRAD_12;
      4'h8:    return BRAD_20;
      4'h9:    return BRAD_21;
      4'hA:    return BRAD_22;
      default: return 32'sd0;
    endcase
  endfunction

  // Clamp a 64-bit signed value into the signed 32-bit range.
  function automatic logic [31:0] sat_s32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648) return 32'h8000_0000;
    else return v[31:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step runs on
// the start edge, so done_o/quotient_o are valid combinationally on the WIDTH-th step.
module seq_divider #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, den_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_den, rem_d, quo_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    src_den = start_i ? divisor_i : den_q;
    trial   = {src_rem, src_quo[WIDTH-1]};
    ge      = trial >= {1'b0, src_den};
    rem_d   = ge ? WIDTH'(trial - {1'b0, src_den}) : trial[WIDTH-1:0];
    quo_d   = {src_quo[WIDTH-2:0], ge};
  end

  assign done_o     = run_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient_o = quo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= divisor_i;
      cnt_q <= CW'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bradford_gain_calculator.sv
// Von Kries gain stage: source XYZ -> Bradford LMS (shared MAC), then
// D65_LMS / src_LMS per channel through one iterative divider.
module bradford_gain_calculator
  import ca_fixed_pkg::*;
#(
  parameter logic [31:0] DST_L     = D65_L,
  parameter logic [31:0] DST_M     = D65_M,
  parameter logic [31:0] DST_S     = D65_S,
  parameter int          DIV_ITERS = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0][31:0] xyz_in,
  input  logic            xyz_valid,
  output logic [2:0][31:0] gain_out,
  output logic            gain_valid,
  output logic            gain_err,
  output logic            busy,
  output state_t          dbg_state
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  // Handshake: xyz_valid is sampled only in IDLE; anything else is dropped.
  // gain_valid pulses for one cycle and gain_out/gain_err hold until the next pulse.
  state_t               state_q;
  logic [2:0][31:0]     xyz_q, lms_q, gain_w_q;
  logic                 err_w_q;
  logic [1:0]           row_q, col_q, chan_q;
  logic [CNT_W-1:0]     div_cnt_q;
  logic signed [63:0]   acc_q;

  logic signed [32:0]   mul_a;
  logic signed [31:0]   mul_b;
  logic signed [63:0]   prod, acc_d;
  logic [31:0]          lms_row_d, dst_sel, lms_sel, chan_gain;
  logic                 lms_bad, chan_err, div_start, div_done, div_last, err_d;
  logic [DIV_ITERS-1:0] div_quo;
  logic [2:0][31:0]     gain_d;

  always_comb begin
    mul_a     = $signed({1'b0, xyz_q[col_q]});
    mul_b     = bradford_coef(row_q, col_q);
    prod      = 64'(mul_a) * 64'(mul_b);
    acc_d     = (col_q == 2'd0) ? prod : acc_q + prod;
    lms_row_d = sat_s32(acc_d >>> Q_FRAC);

    case (chan_q)
      2'd0:    dst_sel = DST_L;
      2'd1:    dst_sel = DST_M;
      default: dst_sel = DST_S;
    endcase
    lms_sel   = lms_q[chan_q];
    lms_bad   = lms_sel[31] || (lms_sel == 32'd0);
    div_start = (state_q == ST_DIV) && (div_cnt_q == '0) && !lms_bad;
    div_last  = (state_q == ST_DIV) && (div_cnt_q == CNT_W'(DIV_ITERS - 1));

    // Non-positive LMS skips the divide but the channel still costs DIV_ITERS cycles.
    if (lms_bad || div_quo > DIV_ITERS'(GAIN_MAX)) begin
      chan_gain = GAIN_MAX;
      chan_err  = 1'b1;
    end else begin
      chan_gain = div_quo[31:0];
      chan_err  = 1'b0;
    end
    gain_d         = gain_w_q;
    gain_d[chan_q] = chan_gain;
    err_d          = err_w_q | chan_err;
  end

  seq_divider #(.WIDTH(DIV_ITERS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (DIV_ITERS'({dst_sel, 16'h0000})),
    .divisor_i  (DIV_ITERS'(lms_sel)),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      xyz_q      <= '0;
      lms_q      <= '0;
      gain_w_q   <= '0;
      err_w_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      chan_q     <= '0;
      div_cnt_q  <= '0;
      acc_q      <= '0;
      gain_out   <= '0;
      gain_valid <= 1'b0;
      gain_err   <= 1'b0;
    end else begin
      gain_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xyz_valid) begin
            xyz_q    <= xyz_in;
            row_q    <= '0;
            col_q    <= '0;
            acc_q    <= '0;
            gain_w_q <= '0;
            err_w_q  <= 1'b0;
            state_q  <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (col_q == 2'd2) begin
            lms_q[row_q] <= lms_row_d;
            acc_q        <= '0;
            col_q        <= '0;
            if (row_q == 2'd2) begin
              row_q     <= '0;
              chan_q    <= '0;
              div_cnt_q <= '0;
              state_q   <= ST_DIV;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end else begin
            acc_q <= acc_d;
            col_q <= col_q + 2'd1;
          end
        end
        ST_DIV: begin
          div_cnt_q <= div_cnt_q + CNT_W'(1);
          if (div_last) begin
            div_cnt_q <= '0;
            if (lms_bad || div_done) begin
              gain_w_q <= gain_d;
              err_w_q  <= err_d;
            end
            if (chan_q == 2'd2) begin
              chan_q     <= '0;
              gain_out   <= gain_d;
              gain_err   <= err_d;
              gain_valid <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              chan_q <= chan_q + 2'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bradford_gain_calculator.sv
// Directed bench for bradford_gain_calculator: vector table plus hand-written
// sequences for busy-drop, mid-job reset and back-to-back acceptance.
module tb_bradford_gain_calculator;
  import ca_fixed_pkg::*;

  localparam int LAT = 153;  // gain_valid shows in the cycle after edge N+153

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0][31:0] xyz_in = '0;
  logic             xyz_valid = 1'b0;
  logic [2:0][31:0] gain_out;
  logic             gain_valid, gain_err, busy;
  state_t           dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] x, y, z;
    logic [31:0] g0, g1, g2;
    logic        err;
    int          tol;
  } vec_t;
  vec_t vecs[6];

  bradford_gain_calculator dut (
    .clk        (clk),
    .rst        (rst),
    .xyz_in     (xyz_in),
    .xyz_valid  (xyz_valid),
    .gain_out   (gain_out),
    .gain_valid (gain_valid),
    .gain_err   (gain_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input longint got, input longint exp, input longint tol);
    longint d;
    n_tests++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, got, exp, tol);
    end
  endtask

  task automatic check_gains(input string tag, input int tol);
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s gain[%0d]", tag, i), longint'(gain_out[i]), longint'(e), tol);
    end
  endtask

  // Returns at the negedge right after the accepting edge N (k = 0).
  task automatic start_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    @(negedge clk);
    xyz_in    = {z, y, x};
    xyz_valid = 1'b1;
    @(negedge clk);
    xyz_valid = 1'b0;
  endtask

  task automatic wait_gain(input int max_k, output int k);
    k = 0;
    while (gain_valid !== 1'b1 && k < max_k) begin
      @(negedge clk);
      k++;
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int k, k2, pulses, busy_cnt, first_k;
    logic [2:0][31:0] g_first;
    logic e_first;

    vecs[0] = '{32'd62291, 32'd65536, 32'd71358, 32'd65536, 32'd65536, 32'd65536, 1'b0, 16};
    vecs[1] = '{32'd71991, 32'd65536, 32'd23321, 32'd51749, 32'd75554, 32'd209634, 1'b0, 16};
    vecs[2] = '{32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0};
    vecs[3] = '{32'd2, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0};
    vecs[4] = '{32'd65536, 32'd0, 32'd0, 32'd68928, 32'h7FFF_FFFF, 32'd1835830, 1'b1, 0};
    vecs[5] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd2, 32'h7FFF_FFFF, 1'b1, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset gain[%0d]", i), longint'(gain_out[i]), 0, 0);
    check("reset gain_valid", longint'(gain_valid), 0, 0);
    check("reset gain_err", longint'(gain_err), 0, 0);
    check("reset busy", longint'(busy), 0, 0);
    check("reset state", longint'(dbg_state), longint'(ST_IDLE), 0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].g0);
      exp_q.push_back(vecs[i].g1);
      exp_q.push_back(vecs[i].g2);
      start_job(vecs[i].x, vecs[i].y, vecs[i].z);
      check($sformatf("v%0d busy after accept", i), longint'(busy), 1, 0);
      wait_gain(400, k);
      check($sformatf("v%0d latency", i), k, LAT, 0);
      check_gains($sformatf("v%0d", i), vecs[i].tol);
      check($sformatf("v%0d err", i), longint'(gain_err), longint'(vecs[i].err), 0);
      @(negedge clk);
      check($sformatf("v%0d valid one cycle", i), longint'(gain_valid), 0, 0);
      check($sformatf("v%0d busy after done", i), longint'(busy), 0, 0);
    end

    // Second strobe 5 clocks into a job is dropped; results come from the first.
    start_job(32'd71991, 32'd65536, 32'd23321);
    pulses = 0; busy_cnt = 0; first_k = -1; g_first = '0; e_first = 1'b0;
    for (int kk = 0; kk < 400; kk++) begin
      if (kk > 0) @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (gain_valid === 1'b1) begin
        pulses++;
        if (first_k < 0) begin
          first_k = kk; g_first = gain_out; e_first = gain_err;
        end
      end
      if (kk == 4) begin
        xyz_in = '0; xyz_valid = 1'b1;
      end else begin
        xyz_valid = 1'b0;
      end
    end
    check("drop pulses", pulses, 1, 0);
    check("drop latency", first_k, LAT, 0);
    check("drop busy cycles", busy_cnt, 154, 0);
    check("drop gain L", longint'(g_first[0]), 51749, 16);
    check("drop gain M", longint'(g_first[1]), 75554, 16);
    check("drop gain S", longint'(g_first[2]), 209634, 16);
    check("drop err", longint'(e_first), 0, 0);

    // Reset 50 clocks into a job aborts it.
    start_job(32'd62291, 32'd65536, 32'd71358);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("abort gain[%0d]", i), longint'(gain_out[i]), 0, 0);
    check("abort gain_valid", longint'(gain_valid), 0, 0);
    check("abort gain_err", longint'(gain_err), 0, 0);
    check("abort busy", longint'(busy), 0, 0);
    rst = 1'b0;
    pulses = 0;
    for (int kk = 0; kk < 200; kk++) begin
      @(negedge clk);
      if (gain_valid === 1'b1) pulses++;
    end
    check("abort no gain_valid", pulses, 0, 0);
    exp_q.push_back(32'd65536); exp_q.push_back(32'd65536); exp_q.push_back(32'd65536);
    start_job(32'd62291, 32'd65536, 32'd71358);
    wait_gain(400, k);
    check("post-abort latency", k, LAT, 0);
    check_gains("post-abort", 16);
    check("post-abort err", longint'(gain_err), 0, 0);

    // Strobe during gain_valid is dropped; strobe on the following cycle is taken.
    start_job(32'd62291, 32'd65536, 32'd71358);
    wait_gain(400, k);
    check("b2b first latency", k, LAT, 0);
    xyz_in = '0; xyz_valid = 1'b1;
    @(negedge clk);
    check("b2b busy after done", longint'(busy), 0, 0);
    xyz_in = {32'd23321, 32'd65536, 32'd71991}; xyz_valid = 1'b1;
    @(negedge clk);
    xyz_valid = 1'b0;
    check("b2b busy after accept", longint'(busy), 1, 0);
    exp_q.push_back(32'd51749); exp_q.push_back(32'd75554); exp_q.push_back(32'd209634);
    wait_gain(400, k2);
    check("b2b valid spacing", 2 + k2, 155, 0);
    check_gains("b2b second", 16);
    check("b2b second err", longint'(gain_err), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
